// File: rtl/rx_sample_packer.sv
// Packs decimated I/Q samples into 16-bit FIFO words (16-bit I,Q pairs or packed {Q8,I8})
// and tracks dropped samples with a sticky overrun flag.
module rx_sample_packer #(
   parameter int AW = 9
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          enable,
   input  logic          mode8,
   input  logic          strobe_in,
   input  logic [15:0]   i_in,
   input  logic [15:0]   q_in,
   input  logic          rd_req,
   output logic [15:0]   rd_data,
   output logic          rd_valid,
   output logic          empty,
   output logic          full,
   output logic [AW:0]   count,
   output logic          overrun,
   input  logic          clear_status
);

   localparam int          DEPTH   = 2 ** AW;
   localparam logic [AW:0] DEPTH_W = {1'b1, {AW{1'b0}}};

   typedef enum logic [1:0] {IDLE, WR_I, WR_Q} state_t;

   state_t          state, state_nx;
   logic [15:0]     i_lat, q_lat;
   logic            m8_lat;
   logic [15:0]     mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     free_words, need;
   logic            fits, capture, drop, wr_en, pop;
   logic [15:0]     wr_data;

   // Round to nearest by adding half an LSB of the 8-bit result; only the
   // positive side can overflow, so it saturates to +127.
   function automatic logic [7:0] to_8bit(input logic [15:0] x);
      logic [16:0] t;
      t = {x[15], x} + 17'h00080;
      return (!t[16] && t[15]) ? 8'h7F : t[15:8];
   endfunction

   assign empty      = (count == '0);
   assign full       = (count == DEPTH_W);
   assign free_words = DEPTH_W - count;
   assign need       = mode8 ? (AW+1)'(1) : (AW+1)'(2);
   assign fits       = (free_words >= need);
   assign pop        = rd_req && !empty;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_nx = state;
      if (!enable) begin
         state_nx = IDLE;
      end else begin
         unique case (state)
            IDLE:    if (strobe_in && fits) state_nx = WR_I;
            WR_I:    state_nx = m8_lat ? IDLE : WR_Q;
            WR_Q:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_comb begin
      capture = 1'b0;
      drop    = 1'b0;
      wr_en   = 1'b0;
      wr_data = i_lat;
      if (enable) begin
         unique case (state)
            IDLE: begin
               capture = strobe_in && fits;
               drop    = strobe_in && !fits;
            end
            WR_I: begin
               drop    = strobe_in;
               wr_en   = 1'b1;
               wr_data = m8_lat ? {to_8bit(q_lat), to_8bit(i_lat)} : i_lat;
            end
            WR_Q: begin
               drop    = strobe_in;
               wr_en   = 1'b1;
               wr_data = q_lat;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!reset_n) begin
         i_lat  <= '0;
         q_lat  <= '0;
         m8_lat <= 1'b0;
      end else if (capture) begin
         i_lat  <= i_in;
         q_lat  <= q_in;
         m8_lat <= mode8;
      end
   end

   // NOTE: storage array has no reset; pointers and count define what is valid.
   always_ff @(posedge clock) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (!enable) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= pop;
         if (pop) rd_data <= mem[rd_ptr];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)          overrun <= 1'b0;
      else if (drop)         overrun <= 1'b1;
      else if (clear_status) overrun <= 1'b0;
   end

endmodule
